// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-path widths, PC increment and fetch FSM encoding
package cpu_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int PC_INC = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, HOLD = 2'd3} fetch_state_e;
endpackage

// File: rtl/if_out_reg.sv
// if_out_reg: fetch-to-decode holding register; load sets valid, clr drops it
module if_out_reg import cpu_pkg::*; #(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          load,
    input  logic          clr,
    input  logic [DW-1:0] d_instr,
    input  logic [AW-1:0] d_pc,
    output logic          valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] pc
);
    always_ff @(posedge clk) begin
        if (!resetb) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= d_instr;
            pc    <= d_pc;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch with PC update and redirect squash
module instr_fetch_unit import cpu_pkg::*; #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int PC_INC = cpu_pkg::PC_INC
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              if_ready
);
    fetch_state_e state, state_d;
    logic drop, drop_d, load, clr;
    logic [ADDR_W-1:0] pc_q;

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state <= IDLE;
            drop  <= 1'b0;
            pc_q  <= '0;
        end else begin
            state <= state_d;
            drop  <= drop_d;
            if (imem_req && imem_gnt) pc_q <= pc;
        end
    end

    // drop marks a response that belongs to a fetch squashed by a redirect
    always_comb begin
        imem_req = (state == REQ) && !redirect;
        pc_en    = redirect || (imem_req && imem_gnt);
        pc_next  = redirect ? redirect_target : pc + ADDR_W'(PC_INC);
        state_d  = state;
        drop_d   = drop;
        load     = 1'b0;
        clr      = 1'b0;
        case (state)
            IDLE: state_d = REQ;
            REQ:  state_d = (imem_req && imem_gnt) ? WAIT : REQ;
            WAIT: begin
                if (imem_rvalid) begin
                    drop_d  = 1'b0;
                    load    = !drop && !redirect;
                    state_d = load ? HOLD : REQ;
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                clr     = if_ready || redirect;
                state_d = clr ? REQ : HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    if_out_reg #(.AW(ADDR_W), .DW(DATA_W)) u_out (
        .clk     (clk),
        .resetb  (resetb),
        .load    (load),
        .clr     (clr),
        .d_instr (imem_rdata),
        .d_pc    (pc_q),
        .valid   (if_valid),
        .instr   (if_instr),
        .pc      (if_pc)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed table, corner sequences and random run against a delivery scoreboard
module tb_instr_fetch_unit;
    localparam logic [31:0] DB = 32'hdead_beef;

    logic clk = 1'b0;
    logic resetb;
    logic [31:0] pc, pc_next, redirect_target, imem_addr, imem_rdata, if_instr, if_pc;
    logic pc_en, redirect, imem_req, imem_gnt, imem_rvalid, if_valid, if_ready;

    instr_fetch_unit dut (
        .clk             (clk),
        .resetb          (resetb),
        .pc              (pc),
        .pc_next         (pc_next),
        .pc_en           (pc_en),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_ready        (if_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int mem_cnt = 0, lat = 1, deliveries = 0;
    logic mem_busy = 1'b0, holding = 1'b0;
    logic [31:0] mem_addr = '0, exp_pc = '0;
    logic s_req, s_pcen, s_valid;
    logic [31:0] s_pcnext, s_addr, s_ifpc, s_instr;

    typedef struct {
        logic        rd;
        logic [31:0] tgt;
        logic        g;
        logic        rdy;
        logic        e_req;
        logic        e_pcen;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // one clock of environment: memory, PC register and delivery scoreboard
    task automatic run_cycle(input logic rd, input logic [31:0] tgt, input logic g, input logic rdy);
        logic ld;
        logic [31:0] nx;
        redirect = rd;
        redirect_target = tgt;
        imem_gnt = g;
        if_ready = rdy;
        imem_rvalid = mem_busy && mem_cnt == 0;
        imem_rdata = imem_rvalid ? (mem_addr ^ DB) : $urandom;
        #1;
        s_req = imem_req; s_pcen = pc_en; s_valid = if_valid;
        s_pcnext = pc_next; s_addr = imem_addr; s_ifpc = if_pc; s_instr = if_instr;
        chk("imem_addr", s_addr, pc);
        chk("pc_next", s_pcnext, rd ? tgt : pc + 32'd4);
        chk1("pc_en", s_pcen, rd | (s_req & g));
        chk1("req_in_hold", s_valid & s_req, 1'b0);
        if (holding) chk1("hold_valid", s_valid, 1'b1);
        if (s_valid) begin
            chk("if_pc", s_ifpc, exp_pc);
            chk("if_instr", s_instr, exp_pc ^ DB);
        end
        if (s_req && g) chk1("single_outstanding", mem_busy, 1'b0);
        if (s_valid && rdy) begin
            deliveries++;
            exp_pc += 32'd4;
        end
        holding = s_valid && !rdy && !rd;
        if (rd) exp_pc = tgt;
        if (mem_busy) begin
            if (mem_cnt == 0) mem_busy = 1'b0;
            else mem_cnt--;
        end
        if (s_req && g) begin
            mem_busy = 1'b1;
            mem_addr = s_addr;
            mem_cnt = lat - 1;
        end
        ld = s_pcen;
        nx = s_pcnext;
        @(posedge clk);
        #1;
        if (ld) pc = nx;
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        redirect = 1'b0; redirect_target = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        @(posedge clk);
        #1;
        resetb = 1'b1;
        pc = '0; exp_pc = '0; mem_busy = 1'b0; holding = 1'b0;
        #1;
        chk1("rst_if_valid", if_valid, 1'b0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk1("rst_imem_req", imem_req, 1'b0);
        chk1("rst_pc_en", pc_en, 1'b0);
    endtask

    task automatic wait_valid(input int maxc);
        s_valid = 1'b0;
        for (int i = 0; i < maxc && !s_valid; i++) run_cycle(1'b0, '0, 1'b1, 1'b0);
        chk1("wait_valid", s_valid, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tv[10];
        logic found;
        int d0;
        tv[0] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        tv[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0};
        tv[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        tv[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'hdead_beef};
        tv[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0};
        tv[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        tv[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 32'hdead_beeb};
        tv[7] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0};
        tv[8] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        tv[9] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'hdead_bee7};
        pc = '0;
        do_reset();
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            run_cycle(tv[i].rd, tv[i].tgt, tv[i].g, tv[i].rdy);
            chk1("tv_req", s_req, tv[i].e_req);
            chk1("tv_pc_en", s_pcen, tv[i].e_pcen);
            chk1("tv_valid", s_valid, tv[i].e_valid);
            if (tv[i].e_valid) begin
                chk("tv_if_pc", s_ifpc, tv[i].e_pc);
                chk("tv_if_instr", s_instr, tv[i].e_instr);
            end
        end
        // grant withheld: request and address must hold, PC must not move
        pc = 32'h0000_0100;
        exp_pc = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, '0, 1'b0, 1'b1);
            chk1("gw_req", s_req, 1'b1);
            chk("gw_addr", s_addr, 32'h0000_0100);
            chk1("gw_pc_en", s_pcen, 1'b0);
        end
        run_cycle(1'b0, '0, 1'b1, 1'b1);
        chk1("gnt_pc_en", s_pcen, 1'b1);
        chk("gnt_pc_next", s_pcnext, 32'h0000_0104);
        wait_valid(8);
        run_cycle(1'b0, '0, 1'b1, 1'b1);
        // PC wrap at the top of the address space
        pc = 32'hffff_fffc;
        exp_pc = 32'hffff_fffc;
        run_cycle(1'b0, '0, 1'b1, 1'b1);
        chk("wrap_pc_next", s_pcnext, 32'h0000_0000);
        chk1("wrap_pc_en", s_pcen, 1'b1);
        wait_valid(8);
        chk("wrap_if_pc", s_ifpc, 32'hffff_fffc);
        run_cycle(1'b0, '0, 1'b1, 1'b1);
        // redirect while waiting; stale response arrives two cycles later
        lat = 3;
        run_cycle(1'b0, '0, 1'b1, 1'b1);
        run_cycle(1'b1, 32'h0040_0000, 1'b0, 1'b1);
        chk1("redir_pc_en", s_pcen, 1'b1);
        chk("redir_pc_next", s_pcnext, 32'h0040_0000);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            run_cycle(1'b0, '0, 1'b0, 1'b1);
            chk1("squash_valid", s_valid, 1'b0);
            found = s_req;
        end
        chk1("redir_req", found, 1'b1);
        chk("redir_addr", s_addr, 32'h0040_0000);
        run_cycle(1'b0, '0, 1'b1, 1'b1);
        wait_valid(10);
        chk("redir_if_pc", s_ifpc, 32'h0040_0000);
        run_cycle(1'b0, '0, 1'b1, 1'b1);
        // decode stalls in HOLD
        lat = 1;
        wait_valid(8);
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b0, '0, 1'b1, 1'b0);
            chk1("stall_valid", s_valid, 1'b1);
            chk("stall_if_pc", s_ifpc, 32'h0040_0004);
            chk("stall_if_instr", s_instr, 32'h0040_0004 ^ DB);
            chk1("stall_no_req", s_req, 1'b0);
        end
        run_cycle(1'b0, '0, 1'b1, 1'b1);
        // reset while holding an instruction
        wait_valid(8);
        do_reset();
        run_cycle(1'b0, '0, 1'b0, 1'b1);
        chk1("post_rst_idle", s_req, 1'b0);
        run_cycle(1'b0, '0, 1'b0, 1'b1);
        chk1("post_rst_req", s_req, 1'b1);
        chk("post_rst_addr", s_addr, 32'h0);
        // random traffic against the scoreboard
        d0 = deliveries;
        for (int i = 0; i < 3000; i++) begin
            lat = int'($urandom_range(1, 3));
            run_cycle(($urandom % 20) == 0, $urandom & 32'hffff_fffc,
                      ($urandom % 10) < 6, ($urandom % 10) < 7);
        end
        chk1("random_progress", (deliveries - d0) > 100, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch-side consumer of the program counter. It takes the current PC value and issues single-outstanding read requests to instruction memory. Each returned instruction is presented to decode through a valid/ready handshake. The block also drives the next-PC value and load enable back into the PC register, covering sequential increment and branch/jump redirects, including squashing of in-flight fetches.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
DATA_W, 32, instruction word width
PC_INC, 4, byte increment applied to PC on each granted fetch

Ports:
clk  input  1  system clock, all state updates on rising edge
resetb  input  1  synchronous active-low reset
pc  input  ADDR_W  current PC register output
pc_next  output  ADDR_W  value the PC register loads when pc_en=1
pc_en  output  1  PC load enable (one-cycle pulse)
redirect  input  1  branch/jump taken, from execute
redirect_target  input  ADDR_W  new PC on redirect
imem_req  output  1  read request to instruction memory
imem_addr  output  ADDR_W  read address
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  DATA_W  read data
if_valid  output  1  instruction available to decode
if_instr  output  DATA_W  fetched instruction
if_pc  output  ADDR_W  address of if_instr
if_ready  input  1  decode accepts instruction

Behaviour:
- Reset (resetb=0 at a clk edge):
  - State goes to IDLE; the drop flag clears.
  - if_valid, if_instr and if_pc clear to 0.
  - imem_req=0 and pc_en=0 while state is IDLE.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: moves to REQ on the first edge with resetb=1.
- Combinational outputs:
  - imem_addr = pc at all times.
  - imem_req = (state==REQ) & ~redirect.
  - pc_next = redirect ? redirect_target : pc + PC_INC. The add wraps modulo 2^ADDR_W; no overflow flag.
  - pc_en = redirect | (imem_req & imem_gnt).
- REQ:
  - imem_req & imem_gnt: capture pc into pc_q, pulse pc_en, go to WAIT.
  - No grant: hold the request. pc is stable because pc_en=0.
  - redirect=1: no request issued, pc_en loads the target, stay in REQ.
- WAIT (exactly one request outstanding):
  - imem_rvalid with drop=0 and redirect=0: if_instr<=imem_rdata, if_pc<=pc_q, if_valid<=1, go to HOLD.
  - imem_rvalid with drop=1: discard the data, clear drop, go to REQ.
  - redirect without rvalid: set drop, pulse pc_en to load the target, stay in WAIT.
  - redirect and rvalid in the same cycle: discard the data, drop stays 0, pc_en loads the target, go to REQ.
- HOLD:
  - if_valid=1. if_instr and if_pc are held stable until the handshake completes.
  - if_valid & if_ready: if_valid<=0, go to REQ.
  - redirect: if_valid<=0, pc_en loads the target, go to REQ. If if_ready is also high that cycle, the transfer counts as completed; decode is responsible for squashing younger instructions.
- Latency:
  - Grant at cycle 0 and rvalid at cycle k (k>=1) gives if_valid at cycle k+1.
  - Minimum spacing is 3 cycles per instruction with single-cycle gnt/rvalid and if_ready held high.
- imem_rvalid in IDLE, REQ or HOLD is a protocol violation and is ignored.
- Reset mid-operation: any outstanding memory response arriving after reset is ignored, because state is IDLE/REQ with drop=0 (a documented limitation; the memory is reset on the same resetb).

Decomposition:
- Shared package (cpu_pkg): ADDR_W, DATA_W, PC_INC, and the fetch-state encoding constants (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, HOLD=2'd3).
- One natural sub-module: if_out_reg, the output holding register with valid/ready and clear.
- The next-PC mux and adder stay inline.

Test Plan:
- Reset then run, with gnt and rvalid tied 1 one cycle after req and if_ready=1, imem returning addr^32'hdead_beef: if_pc sequence is 0,4,8; if_instr = 32'hdead_beef, 32'hdead_beeb, 32'hdead_bee7; pc_en pulses once per fetch.
- gnt withheld for 3 cycles with pc=32'h0000_0100: imem_req stays 1, imem_addr stays 32'h100, pc_en stays 0; on gnt, pc_next=32'h104.
- Redirect to 32'h0040_0000 while in WAIT, rvalid 2 cycles later: stale data never appears on if_valid; next request has imem_addr=32'h0040_0000.
- if_ready=0 for 4 cycles in HOLD: if_valid, if_instr and if_pc are stable; no new imem_req until if_ready=1.
- pc=32'hffff_fffc granted: pc_next=32'h0000_0000 (wrap).
- resetb=0 for one edge while in HOLD: the next cycle has if_valid=0, imem_req=0 and state IDLE, followed by a request.
